// File: rtl/commit_monitor.sv
// Commit-stream checker: tracks expected order, PC and a shadow register file,
// latches the first inconsistency, and detects the jal x0,0 halt self-loop.
package rvfi_pkg;
   typedef struct packed {
      logic        monitor_valid;
      logic [63:0] monitor_order;
      logic [31:0] monitor_inst;
      logic [31:0] monitor_pc_rdata;
      logic [31:0] monitor_pc_wdata;
      logic [4:0]  monitor_rs1_addr;
      logic [4:0]  monitor_rs2_addr;
      logic [31:0] monitor_rs1_rdata;
      logic [31:0] monitor_rs2_rdata;
      logic [4:0]  monitor_rd_addr;
      logic [31:0] monitor_rd_wdata;
      logic [3:0]  monitor_mem_rmask;
      logic [3:0]  monitor_mem_wmask;
   } rvfi_signals_fwd;
endpackage

module commit_monitor
   import rvfi_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h4000_0060,
   parameter logic [31:0] HALT_INST = 32'h0000_006F
) (
   input  logic            clk,
   input  logic            rst,
   input  rvfi_signals_fwd rvfi_i,
   output logic [63:0]     commit_count,
   output logic            error,
   output logic [3:0]      error_code,
   output logic [63:0]     error_order,
   output logic [31:0]     error_pc,
   output logic            halt
);

   localparam logic [3:0] ERR_NONE     = 4'd0;
   localparam logic [3:0] ERR_ORDER    = 4'd1;
   localparam logic [3:0] ERR_PC       = 4'd2;
   localparam logic [3:0] ERR_RS1      = 4'd3;
   localparam logic [3:0] ERR_RS2      = 4'd4;
   localparam logic [3:0] ERR_X0       = 4'd5;
   localparam logic [3:0] ERR_MASK     = 4'd6;
   localparam logic [3:0] ERR_POSTHALT = 4'd7;

   logic [63:0] exp_order;
   logic [31:0] exp_pc;
   logic [31:0] shadow [1:31];

   logic        commit;
   logic [31:0] rs1_exp;
   logic [31:0] rs2_exp;
   logic [3:0]  fail_code;
   logic        halt_hit;

   assign commit = rvfi_i.monitor_valid;

   // x0 has no shadow entry, so a zero address leaves the expected value at 0.
   always_comb begin
      rs1_exp = '0;
      rs2_exp = '0;
      for (int i = 1; i < 32; i++) begin
         if (rvfi_i.monitor_rs1_addr == 5'(i)) rs1_exp = shadow[i];
         if (rvfi_i.monitor_rs2_addr == 5'(i)) rs2_exp = shadow[i];
      end
   end

   always_comb begin
      fail_code = ERR_NONE;
      if (rvfi_i.monitor_order != exp_order)
         fail_code = ERR_ORDER;
      else if (rvfi_i.monitor_pc_rdata != exp_pc)
         fail_code = ERR_PC;
      else if (rvfi_i.monitor_rs1_rdata != rs1_exp)
         fail_code = ERR_RS1;
      else if (rvfi_i.monitor_rs2_rdata != rs2_exp)
         fail_code = ERR_RS2;
      else if (rvfi_i.monitor_rd_addr == 5'd0 && rvfi_i.monitor_rd_wdata != 32'd0)
         fail_code = ERR_X0;
      else if (rvfi_i.monitor_mem_rmask != 4'd0 && rvfi_i.monitor_mem_wmask != 4'd0)
         fail_code = ERR_MASK;
      else if (halt)
         fail_code = ERR_POSTHALT;
   end

   assign halt_hit = (rvfi_i.monitor_inst == HALT_INST) &&
                     (rvfi_i.monitor_pc_wdata == rvfi_i.monitor_pc_rdata);

   // State advances from the commit itself, so a single skip reports only once.
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_order    <= '0;
         exp_pc       <= RESET_PC;
         commit_count <= '0;
         error        <= 1'b0;
         error_code   <= ERR_NONE;
         error_order  <= '0;
         error_pc     <= '0;
         halt         <= 1'b0;
      end else if (commit) begin
         exp_order    <= rvfi_i.monitor_order + 64'd1;
         exp_pc       <= rvfi_i.monitor_pc_wdata;
         commit_count <= commit_count + 64'd1;
         if (halt_hit) halt <= 1'b1;
         if (!error && fail_code != ERR_NONE) begin
            error       <= 1'b1;
            error_code  <= fail_code;
            error_order <= rvfi_i.monitor_order;
            error_pc    <= rvfi_i.monitor_pc_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 1; i < 32; i++) begin
         if (rst)
            shadow[i] <= '0;
         else if (commit && rvfi_i.monitor_rd_addr == 5'(i))
            shadow[i] <= rvfi_i.monitor_rd_wdata;
      end
   end

endmodule
